// File: rtl/adder_pipe.sv
// adder_pipe: add/subtract with the carry chain split into STAGES chunk-wide
// pipeline stages, signed overflow detection and optional signed saturation.
`default_nettype none

module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  input  logic             SAT,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             OVF
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Slot k holds a transaction about to add chunk k; operands are stored with
  // B already inverted for subtract, so SUB needs no further delay.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cry_q;
  logic [STAGES-1:0] sat_q;
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  part_q [STAGES];

  logic [CW:0]       chunk_sum [STAGES];
  logic [WIDTH-1:0]  part_next [STAGES];
  logic [STAGES-1:0] cry_next;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, a_q[k][k*CW +: CW]} + {1'b0, b_q[k][k*CW +: CW]}
                   + {{CW{1'b0}}, cry_q[k]};
      part_next[k] = part_q[k];
      part_next[k][k*CW +: CW] = chunk_sum[k][CW-1:0];
      cry_next[k]  = chunk_sum[k][CW];
    end
  end

  logic [WIDTH-1:0] res_raw;
  logic             res_ovf;
  logic [WIDTH-1:0] res_sat;

  always_comb begin
    res_raw = part_next[LAST];
    res_ovf = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
              (res_raw[WIDTH-1] != a_q[LAST][WIDTH-1]);
    res_sat = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q     <= '0;
      cry_q     <= '0;
      sat_q     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        part_q[k] <= '0;
      end
      OUT_VALID <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      OVF       <= 1'b0;
    end else if (EN) begin
      vld_q[0]  <= IN_VALID;
      a_q[0]    <= A;
      b_q[0]    <= SUB ? ~B : B;
      cry_q[0]  <= SUB ? ~Cin : Cin;
      sat_q[0]  <= SAT;
      part_q[0] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        vld_q[k+1]  <= vld_q[k];
        a_q[k+1]    <= a_q[k];
        b_q[k+1]    <= b_q[k];
        cry_q[k+1]  <= cry_next[k];
        sat_q[k+1]  <= sat_q[k];
        part_q[k+1] <= part_next[k];
      end
      OUT_VALID <= vld_q[LAST];
      // Bubbles leave the last valid result on Sum/Cout/OVF.
      if (vld_q[LAST]) begin
        Sum  <= (sat_q[LAST] && res_ovf) ? res_sat : res_raw;
        Cout <= cry_next[LAST];
        OVF  <= res_ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_pipe.sv
// Randomized scoreboard bench for adder_pipe with directed corner cases.
`default_nettype none

module tb_adder_pipe;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, in_valid, cin, sub, sat;
  logic [WIDTH-1:0] a, b;
  logic             out_valid, cout, ovf;
  logic [WIDTH-1:0] sum;

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .CLK(clk), .RST(rst), .EN(en), .IN_VALID(in_valid),
    .A(a), .B(b), .Cin(cin), .SUB(sub), .SAT(sat),
    .OUT_VALID(out_valid), .Sum(sum), .Cout(cout), .OVF(ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  bit   last_upd = 1'b0;
  bit   last_rst = 1'b1;
  bit   mon_on = 1'b0;

  logic             p_valid, p_cout, p_ovf;
  logic [WIDTH-1:0] p_sum;

  always @(posedge clk) begin
    last_upd = en && !rst;
    last_rst = rst;
    if (en && !rst) en_cnt++;
  end

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic ic, input logic isub, input logic isat);
    exp_t e;
    int sa, sb2, r, ua, ub;
    logic [31:0] rv;
    sa  = int'($signed(ia));
    sb2 = int'($signed(ib));
    ua  = int'(ia);
    ub  = int'(ib);
    r   = isub ? sa - sb2 - int'(ic) : sa + sb2 + int'(ic);
    rv  = r;
    e.ovf  = (r > 32767) || (r < -32768);
    e.cout = isub ? (ua >= ub + int'(ic)) : ((ua + ub + int'(ic)) > 65535);
    e.sum  = rv[WIDTH-1:0];
    if (isat && e.ovf) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
    e.due = 0;
    return e;
  endfunction

  // Monitor: pops on every freshly produced result, otherwise checks holds.
  always @(negedge clk) begin
    if (mon_on && !last_rst) begin
      if (sb_q.size() > 0 && sb_q[0].due < en_cnt) begin
        checks++; errors++;
        $display("FAIL missed_result: expected sum=%h due at enabled edge %0d, now %0d",
                 sb_q[0].sum, sb_q[0].due, en_cnt);
        void'(sb_q.pop_front());
      end
      if (last_upd && out_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no output",
                   sum, cout, ovf);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || en_cnt != e.due) begin
            errors++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b at edge %0d, required sum=%h cout=%b ovf=%b at edge %0d",
                     sum, cout, ovf, en_cnt, e.sum, e.cout, e.ovf, e.due);
          end
        end
      end else begin
        checks++;
        if (sum !== p_sum || cout !== p_cout || ovf !== p_ovf ||
            (!last_upd && out_valid !== p_valid)) begin
          errors++;
          $display("FAIL hold: got v=%b sum=%h cout=%b ovf=%b, required held v=%b sum=%h cout=%b ovf=%b",
                   out_valid, sum, cout, ovf, p_valid, p_sum, p_cout, p_ovf);
        end
      end
    end
    p_valid = out_valid; p_sum = sum; p_cout = cout; p_ovf = ovf;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ic, input logic isub, input logic isat);
    exp_t e;
    rst = 1'b0; en = 1'b1; in_valid = v;
    a = ia; b = ib; cin = ic; sub = isub; sat = isat;
    if (v) begin
      e = model(ia, ib, ic, isub, isat);
      e.due = en_cnt + 1 + STAGES;
      sb_q.push_back(e);
    end
    step();
  endtask

  task automatic drive_exp(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                           input logic ic, input logic isub, input logic isat,
                           input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    exp_t e;
    rst = 1'b0; en = 1'b1; in_valid = 1'b1;
    a = ia; b = ib; cin = ic; sub = isub; sat = isat;
    e.sum = es; e.cout = ec; e.ovf = eo; e.due = en_cnt + 1 + STAGES;
    sb_q.push_back(e);
    step();
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0; en = 1'b0; in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      sub = 1'($urandom); sat = 1'($urandom);
      step();
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%b sum=%h cout=%b ovf=%b, required all zero",
               tag, out_valid, sum, cout, ovf);
    end
  endtask

  task automatic do_reset(input int n, input logic ien);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; en = ien; in_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      sub = 1'($urandom); sat = 1'($urandom);
      sb_q.delete();
      step();
      check_reset_state("reset_state");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    do_reset(2, 1'b1);
    mon_on = 1'b1;

    // Directed corners; the first is issued on the edge right after reset.
    drive_exp(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    drive_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive_exp(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0);
    drive_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drive_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    drive_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
    idle(1);
    drive_exp(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
    idle(STAGES + 1);

    // Stall after the second of four back-to-back transactions.
    drive_exp(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    drive_exp(16'h0010, 16'h0020, 1'b1, 1'b1, 1'b0, 16'hFFEF, 1'b0, 1'b0);
    stall(2);
    drive_exp(16'hF000, 16'h2000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0);
    drive_exp(16'h4000, 16'h4000, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    idle(STAGES + 1);

    // Reset with three in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    do_reset(1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_valid: got out_valid=%b, required 0", out_valid);
      end
    end

    // Reset wins over a stall.
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0);
    do_reset(1, 1'b0);
    idle(STAGES + 2);

    // Randomized traffic with stalls and bubbles.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001;
      if ($urandom_range(0, 4) == 0) stall(1);
      else drive(1'($urandom_range(0, 9) < 7), ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(STAGES + 4);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
